// File: rtl/ctrl_pkg.sv
// Shared types and codes for the multi-cycle MIPS main control FSM.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADDR  = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXEC     = 4'd7,
    S_RWB      = 4'd8,
    S_ADDIWB   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] SRCB_B     = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_word_t;

endpackage

// File: rtl/ctrl_outdec.sv
// Pure state -> control-word decoder. FETCH strobes are raw here and
// qualified with memory ready by the top.
module ctrl_outdec
  import ctrl_pkg::*;
(
  input  state_t     state_i,
  output ctrl_word_t cw_o
);

  always_comb begin
    cw_o = '0;
    case (state_i)
      S_FETCH: begin
        cw_o.mem_rd    = 1'b1;
        cw_o.ir_write  = 1'b1;
        cw_o.pc_write  = 1'b1;
        cw_o.alu_src_b = SRCB_FOUR;
        cw_o.alu_op    = ALUOP_ADD;
        cw_o.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        cw_o.alu_src_b = SRCB_IMMSH;
        cw_o.alu_op    = ALUOP_ADD;
      end
      S_MEMADDR: begin
        cw_o.alu_src_a = 1'b1;
        cw_o.alu_src_b = SRCB_IMM;
        cw_o.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        cw_o.mem_rd = 1'b1;
        cw_o.iord   = 1'b1;
      end
      S_MEMWB: begin
        cw_o.reg_write  = 1'b1;
        cw_o.mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        cw_o.mem_wr = 1'b1;
        cw_o.iord   = 1'b1;
      end
      S_EXEC: begin
        cw_o.alu_src_a = 1'b1;
        cw_o.alu_src_b = SRCB_B;
        cw_o.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        cw_o.reg_write = 1'b1;
        cw_o.reg_dst   = 1'b1;
      end
      S_ADDIWB: cw_o.reg_write = 1'b1;
      S_BRANCH: begin
        cw_o.alu_src_a     = 1'b1;
        cw_o.alu_src_b     = SRCB_B;
        cw_o.alu_op        = ALUOP_SUB;
        cw_o.pc_write_cond = 1'b1;
        cw_o.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        cw_o.pc_write  = 1'b1;
        cw_o.pc_source = PCSRC_JUMP;
      end
      default: cw_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM. Optional bne support via `define CTRL_BNE_EN.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [OP_W-1:0]    Op_i,
  input  logic               mem_ready_i,
  output logic               PCWrite_o,
  output logic               PCWriteCond_o,
  output logic [1:0]         PCSource_o,
  output logic               IorD_o,
  output logic               MemRd_o,
  output logic               MemWr_o,
  output logic               IRWrite_o,
  output logic               ALUSrcA_o,
  output logic [1:0]         ALUSrcB_o,
  output logic [ALUOP_W-1:0] ALUOp_o,
  output logic               RegDst_o,
  output logic               MemtoReg_o,
  output logic               RegWrite_o,
`ifdef CTRL_BNE_EN
  output logic               BranchNe_o,
`endif
  output logic               illegal_o,
  output logic [3:0]         state_o
);

  state_t     state_q, state_d;
  ctrl_word_t cw;
  logic       illegal_d;
  logic       fetch_ok;
  logic [5:0] op;

  assign op = 6'(Op_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_FETCH;
      S_FETCH: if (mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW, OP_ADDI: state_d = S_MEMADDR;
          OP_RTYPE:              state_d = S_EXEC;
          OP_BEQ:                state_d = S_BRANCH;
          OP_J:                  state_d = S_JUMP;
`ifdef CTRL_BNE_EN
          OP_BNE:                state_d = S_BRANCH;
`endif
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADDR: begin
        case (op)
          OP_LW:   state_d = S_MEMREAD;
          OP_SW:   state_d = S_MEMWRITE;
          OP_ADDI: state_d = S_ADDIWB;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMREAD:  if (mem_ready_i) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready_i) state_d = S_FETCH;
      S_EXEC:     state_d = S_RWB;
      S_MEMWB, S_RWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:    state_d = S_IDLE;
    endcase
  end

`ifdef CTRL_BNE_EN
  // Op_i is gone by BRANCH, so remember whether DECODE saw bne.
  logic bne_q;
  always_ff @(posedge clk_i) begin
    if (rst_i)                   bne_q <= 1'b0;
    else if (state_q == S_DECODE) bne_q <= (op == OP_BNE);
  end
  assign BranchNe_o = (state_q == S_BRANCH) & bne_q;
`endif

  ctrl_outdec u_outdec (
    .state_i (state_q),
    .cw_o    (cw)
  );

  assign fetch_ok      = (state_q != S_FETCH) | mem_ready_i;
  assign PCWrite_o     = cw.pc_write & fetch_ok;
  assign IRWrite_o     = cw.ir_write & fetch_ok;
  assign PCWriteCond_o = cw.pc_write_cond;
  assign PCSource_o    = cw.pc_source;
  assign IorD_o        = cw.iord;
  assign MemRd_o       = cw.mem_rd;
  assign MemWr_o       = cw.mem_wr;
  assign ALUSrcA_o     = cw.alu_src_a;
  assign ALUSrcB_o     = cw.alu_src_b;
  assign ALUOp_o       = ALUOP_W'(cw.alu_op);
  assign RegDst_o      = cw.reg_dst;
  assign MemtoReg_o    = cw.mem_to_reg;
  assign RegWrite_o    = cw.reg_write;
  assign illegal_o     = illegal_d;
  assign state_o       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Cycle-by-cycle scoreboard bench for multicycle_control.
module tb_multicycle_control;
  import ctrl_pkg::*;

  localparam logic [5:0] T_R = 6'h00, T_J = 6'h02, T_BEQ = 6'h04, T_BNE = 6'h05;
  localparam logic [5:0] T_ADDI = 6'h08, T_LW = 6'h23, T_SW = 6'h2b, T_BAD = 6'h3f;

  logic       clk = 1'b0;
  logic       rst, start, rdy;
  logic [5:0] op;
  logic       pcw, pcwc, iord, mrd, mwr, irw, srca, rdst, m2r, rw, ill;
  logic [1:0] pcs, srcb, aluop;
  logic [3:0] st;
  logic [16:0] ctl_o;
`ifdef CTRL_BNE_EN
  logic       bne_o;
`endif

  always #5 clk = ~clk;

  multicycle_control #(.OP_W(6), .ALUOP_W(2)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .Op_i(op), .mem_ready_i(rdy),
    .PCWrite_o(pcw), .PCWriteCond_o(pcwc), .PCSource_o(pcs), .IorD_o(iord),
    .MemRd_o(mrd), .MemWr_o(mwr), .IRWrite_o(irw), .ALUSrcA_o(srca),
    .ALUSrcB_o(srcb), .ALUOp_o(aluop), .RegDst_o(rdst), .MemtoReg_o(m2r),
    .RegWrite_o(rw),
`ifdef CTRL_BNE_EN
    .BranchNe_o(bne_o),
`endif
    .illegal_o(ill), .state_o(st)
  );

  assign ctl_o = {pcw, pcwc, pcs, iord, mrd, mwr, irw, srca, srcb, aluop, rdst, m2r, rw, ill};

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [16:0] ctl;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected control word for a state, straight from the state table.
  function automatic logic [16:0] spec_ctl(input state_t s, input logic m, input logic il);
    logic p_w, p_wc, io, rd, wr, ir, sa, rdt, mr, w;
    logic [1:0] ps, sb_, ao;
    {p_w, p_wc, io, rd, wr, ir, sa, rdt, mr, w} = '0;
    {ps, sb_, ao} = '0;
    case (s)
      S_FETCH:    begin rd = 1; sb_ = 2'd1; ir = m; p_w = m; end
      S_DECODE:   sb_ = 2'd3;
      S_MEMADDR:  begin sa = 1; sb_ = 2'd2; end
      S_MEMREAD:  begin rd = 1; io = 1; end
      S_MEMWB:    begin w = 1; mr = 1; end
      S_MEMWRITE: begin wr = 1; io = 1; end
      S_EXEC:     begin sa = 1; ao = 2'd2; end
      S_RWB:      begin w = 1; rdt = 1; end
      S_ADDIWB:   w = 1;
      S_BRANCH:   begin sa = 1; ao = 2'd1; p_wc = 1; ps = 2'd1; end
      S_JUMP:     begin p_w = 1; ps = 2'd2; end
      default:    ;
    endcase
    return {p_w, p_wc, ps, io, rd, wr, ir, sa, sb_, ao, rdt, mr, w, il};
  endfunction

  // Drive one cycle of inputs, then compare the outputs visible in that cycle.
  task automatic cyc(input string tag, input logic r, input logic s, input logic [5:0] o,
                     input logic m, input state_t es, input logic il);
    exp_t e;
    @(negedge clk);
    rst = r; start = s; op = o; rdy = m;
    e.tag = tag; e.st = es; e.ctl = spec_ctl(es, m, il);
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    check_eq({e.tag, ".state"}, 32'(st), 32'(e.st));
    check_eq({e.tag, ".ctl"}, 32'(ctl_o), 32'(e.ctl));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bne_ill;
`ifdef CTRL_BNE_EN
    bne_ill = 1'b0;
`else
    bne_ill = 1'b1;
`endif
    rst = 1'b1; start = 1'b0; op = '0; rdy = 1'b0;
    repeat (2) @(negedge clk);

    cyc("rst_idle",   0, 0, T_LW,  1, S_IDLE,     0);
    cyc("idle_start", 0, 1, T_LW,  1, S_IDLE,     0);
    // lw, zero wait states; start and opcode ignored in FETCH
    cyc("lw_f",       0, 1, T_BAD, 1, S_FETCH,    0);
    cyc("lw_d",       0, 0, T_LW,  1, S_DECODE,   0);
    cyc("lw_a",       0, 0, T_LW,  1, S_MEMADDR,  0);
    cyc("lw_r",       0, 0, T_LW,  1, S_MEMREAD,  0);
    cyc("lw_wb",      0, 0, T_BAD, 1, S_MEMWB,    0);
    // fetch stall then R-type
    cyc("fw_0",       0, 0, T_R,   0, S_FETCH,    0);
    cyc("fw_1",       0, 0, T_R,   0, S_FETCH,    0);
    cyc("fw_2",       0, 0, T_R,   1, S_FETCH,    0);
    cyc("r_d",        0, 0, T_R,   1, S_DECODE,   0);
    cyc("r_x",        0, 0, T_BAD, 1, S_EXEC,     0);
    cyc("r_wb",       0, 0, T_BAD, 1, S_RWB,      0);
    // sw with three wait cycles
    cyc("sw_f",       0, 0, T_SW,  1, S_FETCH,    0);
    cyc("sw_d",       0, 0, T_SW,  1, S_DECODE,   0);
    cyc("sw_a",       0, 0, T_SW,  1, S_MEMADDR,  0);
    cyc("sw_w0",      0, 0, T_SW,  0, S_MEMWRITE, 0);
    cyc("sw_w1",      0, 0, T_SW,  0, S_MEMWRITE, 0);
    cyc("sw_w2",      0, 0, T_SW,  0, S_MEMWRITE, 0);
    cyc("sw_w3",      0, 0, T_SW,  1, S_MEMWRITE, 0);
    // addi
    cyc("ad_f",       0, 0, T_ADDI, 1, S_FETCH,   0);
    cyc("ad_d",       0, 0, T_ADDI, 1, S_DECODE,  0);
    cyc("ad_a",       0, 0, T_ADDI, 1, S_MEMADDR, 0);
    cyc("ad_wb",      0, 0, T_ADDI, 1, S_ADDIWB,  0);
    // illegal opcode
    cyc("il_f",       0, 0, T_BAD, 1, S_FETCH,    0);
    cyc("il_d",       0, 0, T_BAD, 1, S_DECODE,   1);
    // beq then j
    cyc("bq_f",       0, 0, T_BEQ, 1, S_FETCH,    0);
    cyc("bq_d",       0, 0, T_BEQ, 1, S_DECODE,   0);
    cyc("bq_b",       0, 0, T_BAD, 1, S_BRANCH,   0);
`ifdef CTRL_BNE_EN
    check_eq("bq_b.bne", 32'(bne_o), 32'd0);
`endif
    cyc("j_f",        0, 0, T_J,   1, S_FETCH,    0);
    cyc("j_d",        0, 0, T_J,   1, S_DECODE,   0);
    cyc("j_j",        0, 0, T_BAD, 1, S_JUMP,     0);
    // bne: branch when enabled, illegal otherwise
    cyc("bn_f",       0, 0, T_BNE, 1, S_FETCH,    0);
    cyc("bn_d",       0, 0, T_BNE, 1, S_DECODE,   bne_ill);
`ifdef CTRL_BNE_EN
    cyc("bn_b",       0, 0, T_BAD, 1, S_BRANCH,   0);
    check_eq("bn_b.bne", 32'(bne_o), 32'd1);
`endif
    // reset in the middle of a stalled load
    cyc("rs_f",       0, 0, T_LW,  1, S_FETCH,    0);
    cyc("rs_d",       0, 0, T_LW,  1, S_DECODE,   0);
    cyc("rs_a",       0, 0, T_LW,  1, S_MEMADDR,  0);
    cyc("rs_r0",      0, 0, T_LW,  0, S_MEMREAD,  0);
    cyc("rs_r1",      1, 1, T_LW,  1, S_MEMREAD,  0);
    cyc("rs_idle0",   0, 0, T_LW,  1, S_IDLE,     0);
    cyc("rs_idle1",   0, 0, T_LW,  1, S_IDLE,     0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
